// File: rtl/cpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package  : cpu_pkg
// Purpose  : Shared widths, fetch FSM state type and fetch buffer entry type.
// Revision : 1.0
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [1:0] c_st_req  = 2'd0;
  localparam logic [1:0] c_st_hold = 2'd1;
  localparam logic [1:0] c_st_drop = 2'd2;

  typedef enum logic [1:0] {
    REQ  = c_st_req,
    HOLD = c_st_hold,
    DROP = c_st_drop
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fetch_skid_buf
// Purpose  : 2-entry valid/ready buffer (output register + skid) for {pc, instr}.
// Revision : 1.0
// ----------------------------------------------------------------------------
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  input  fetch_entry_t in_data_i,
  output logic         out_valid_o,
  output fetch_entry_t out_data_o,
  input  logic         out_ready_i
);

  fetch_entry_t out_q, out_d;
  fetch_entry_t skid_q, skid_d;
  logic         out_vld_q, out_vld_d;
  logic         skid_vld_q, skid_vld_d;

  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush_i) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (out_vld_q && !out_ready_i) begin
      // Output stalled: the output register holds, a new word lands in skid.
      if (in_valid_i && !skid_vld_q) begin
        skid_d     = in_data_i;
        skid_vld_d = 1'b1;
      end
    end else if (skid_vld_q) begin
      out_d      = skid_q;
      out_vld_d  = 1'b1;
      skid_vld_d = in_valid_i;
      if (in_valid_i) skid_d = in_data_i;
    end else begin
      out_vld_d = in_valid_i;
      if (in_valid_i) out_d = in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_valid_o = out_vld_q;
  assign out_data_o  = out_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : instr_fetch
// Purpose  : Sequential instruction fetch, one outstanding request, 2-deep
//            output buffer, redirect flush with in-flight response drop.
// Options  : FETCH_MISALIGN_TRAP_EN adds sticky fetch_fault on misaligned redirect.
// Revision : 1.0
// ----------------------------------------------------------------------------
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic            fetch_fault,
`endif
  input  logic [XLEN-1:0] redirect_pc
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            run_q;
  logic            w_fault;
  logic            w_ack;
  logic            w_push;
  logic [XLEN-1:0] w_rpc;
  fetch_entry_t    w_in_entry;
  fetch_entry_t    w_out_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  assign w_fault     = fault_q;
  assign fetch_fault = fault_q;
`else
  assign w_fault = 1'b0;
`endif

  assign w_rpc     = redirect_pc & ~XLEN'(INSTR_BYTES - 1);
  // DROP keeps requesting even under a fault so the in-flight request completes.
  assign imem_req  = run_q && (((state_q == REQ) && !w_fault) || (state_q == DROP));
  assign imem_addr = pc_q;
  assign w_ack     = imem_ack && imem_req;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    w_push   = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_d  = fault_q;
`endif
    if (redirect) begin
      if (imem_req && !w_ack) begin
        state_d  = DROP;
        target_d = w_rpc;
      end else begin
        state_d  = REQ;
        pc_d     = w_rpc;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_d  = |redirect_pc[1:0];
`endif
    end else begin
      case (state_q)
        REQ: begin
          if (w_ack) begin
            w_push = 1'b1;
            pc_d   = pc_q + XLEN'(INSTR_BYTES);
            if (instr_valid && !instr_ready) state_d = HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) state_d = REQ;
        end
        DROP: begin
          if (w_ack) begin
            state_d = REQ;
            pc_d    = target_q;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      target_q <= RESET_PC;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      run_q    <= 1'b1;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end
`endif

  assign w_in_entry = '{pc: pc_q, instr: imem_rdata};

  fetch_skid_buf u_skid_buf (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect),
    .in_valid_i  (w_push),
    .in_data_i   (w_in_entry),
    .out_valid_o (instr_valid),
    .out_data_o  (w_out_entry),
    .out_ready_i (instr_ready)
  );

  assign instr    = w_out_entry.instr;
  assign instr_pc = w_out_entry.pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_instr_fetch
// Purpose  : Randomized self-checking bench for instr_fetch against a
//            transaction-level fetch/occupancy model.
// Options  : FETCH_MISALIGN_TRAP_EN also exercises fetch_fault.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_fault;
`endif

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
`ifdef FETCH_MISALIGN_TRAP_EN
    .fetch_fault (fetch_fault),
`endif
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: words held, next pc the decoder should see, next pc to fetch.
  int          m_occ;
  logic [31:0] m_exp_pc;
  logic [31:0] m_fetch_pc;
  bit          m_drop;
  bit          m_fault;
  bit          p_req;
  bit          p_ack;
  logic [31:0] p_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0100;
      1:       return 32'hFFFF_FFF8;
      2:       return r & ~32'h3;
      default: return r;
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    redirect_pc = '0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", imem_req, 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0000_0000);
    check_eq("rst_instr", instr, 32'd0);
    check_eq("rst_instr_pc", instr_pc, 32'd0);
    check_eq("rst_valid", instr_valid, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check_eq("rst_fault", fetch_fault, 32'd0);
`endif
    rst = 1'b0;
    #2;
    check_eq("req_first_cycle", imem_req, 32'd0);
    m_occ = 0; m_exp_pc = '0; m_fetch_pc = '0;
    m_drop = 1'b0; m_fault = 1'b0;
    p_req = 1'b0; p_ack = 1'b0; p_addr = '0;
  endtask

  task automatic cycle(input int ack_pct, input int rdy_pct, input int rdr_pct,
                       input bit frc, input logic [31:0] fpc);
    logic [31:0] rpc_eff;
    bit          useful;
    bit          cons;
    bit          exp_req;
    @(posedge clk); #1;
    imem_ack    = imem_req && ($urandom_range(0, 99) < ack_pct);
    imem_rdata  = imem_ack ? mem_word(imem_addr) : 32'hBAD0_BAD0;
    instr_ready = ($urandom_range(0, 99) < rdy_pct);
    redirect    = frc || ($urandom_range(0, 99) < rdr_pct);
    redirect_pc = frc ? fpc : pick_target();
    #3;
    exp_req = m_drop || (!m_fault && (m_occ < 2));
    check_eq("imem_req", imem_req, exp_req);
    check_eq("instr_valid", instr_valid, (m_occ > 0));
`ifdef FETCH_MISALIGN_TRAP_EN
    check_eq("fetch_fault", fetch_fault, m_fault);
`endif
    if (m_occ > 0) begin
      check_eq("instr_pc", instr_pc, m_exp_pc);
      check_eq("instr", instr, mem_word(m_exp_pc));
    end
    if (p_req && !p_ack && imem_req) check_eq("addr_hold", imem_addr, p_addr);
    useful = imem_ack && !redirect && !m_drop;
    if (useful) check_eq("fetch_addr", imem_addr, m_fetch_pc);
    cons   = (m_occ > 0) && instr_ready;
    p_req  = imem_req;
    p_ack  = imem_ack;
    p_addr = imem_addr;
    if (redirect) begin
      rpc_eff    = redirect_pc & ~32'h3;
      m_drop     = imem_req && !imem_ack;
      m_occ      = 0;
      m_exp_pc   = rpc_eff;
      m_fetch_pc = rpc_eff;
`ifdef FETCH_MISALIGN_TRAP_EN
      m_fault    = (redirect_pc[1:0] != 2'b00);
`endif
    end else begin
      if (imem_ack) m_drop = 1'b0;
      if (cons) begin
        m_occ--;
        m_exp_pc = m_exp_pc + 32'd4;
      end
      if (useful) begin
        m_occ++;
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
  endtask

  initial begin
    do_reset();
    // Back-to-back stream from reset
    repeat (6) cycle(100, 100, 0, 1'b0, 32'h0);
    // Decoder stall fills both entries
    repeat (3) cycle(100, 0, 0, 1'b0, 32'h0);
    repeat (4) cycle(100, 100, 0, 1'b0, 32'h0);
    // Redirect while waiting; the old response arrives two cycles later
    cycle(0, 100, 0, 1'b1, 32'h0000_0100);
    cycle(0, 100, 0, 1'b0, 32'h0);
    repeat (4) cycle(100, 100, 0, 1'b0, 32'h0);
    // Redirect coincident with an ack
    cycle(100, 100, 0, 1'b1, 32'h0000_0240);
    repeat (3) cycle(100, 100, 0, 1'b0, 32'h0);
    // Address wrap past FFFF_FFFC
    cycle(100, 100, 0, 1'b1, 32'hFFFF_FFF8);
    repeat (5) cycle(100, 100, 0, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    cycle(100, 100, 0, 1'b1, 32'h0000_0102);
    repeat (3) cycle(100, 100, 0, 1'b0, 32'h0);
    cycle(100, 100, 0, 1'b1, 32'h0000_0200);
    repeat (4) cycle(100, 100, 0, 1'b0, 32'h0);
`endif
    for (int ph = 0; ph < 40; ph++) begin
      int a, r, d;
      a = $urandom_range(20, 100);
      r = $urandom_range(0, 100);
      d = $urandom_range(0, 15);
      repeat (60) cycle(a, r, d, 1'b0, 32'h0);
      if (ph == 20) do_reset();
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC SHALL default to 32'h0000_0000; it is the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 imem_req  output  1  fetch request, level-held until imem_ack.
REQ-005 imem_addr  output  32  word-aligned fetch address, stable while imem_req=1.
REQ-006 imem_ack  input  1  memory response strobe, valid only while imem_req=1.
REQ-007 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-008 instr  output  32  instruction word presented to the decoder.
REQ-009 instr_pc  output  32  address of the word on instr.
REQ-010 instr_valid  output  1  instr/instr_pc hold a live word.
REQ-011 instr_ready  input  1  decoder consumes the word when instr_valid & instr_ready.
REQ-012 redirect  input  1  branch/jump flush strobe; it has priority over every other event.
REQ-013 redirect_pc  input  32  new fetch address, sampled when redirect=1.

Function
REQ-014 The block SHALL keep one outstanding memory request at most.
REQ-015 The block SHALL provide a 2-deep buffer: the output register plus one skid entry.
REQ-016 The FSM SHALL have exactly three states: REQ (imem_req=1, imem_addr=pc), HOLD (imem_req=0, skid full), and DROP (imem_req=1, old address held, response discarded).
REQ-017 In REQ with imem_ack, the word SHALL go to the output register if it is empty or consumed this cycle, else to skid with a move to HOLD; pc SHALL advance by 4, modulo 2^32 (wrap from FFFF_FFFC to 0).
REQ-018 HOLD SHALL return to REQ on the cycle the output is consumed; skid then moves to the output register on that edge.
REQ-019 Output latency SHALL be: instr_valid rises the cycle after imem_ack, giving a sustained throughput of 1 word per cycle with imem_ack held high and instr_ready=1.
REQ-020 instr_valid SHALL stay high and instr/instr_pc SHALL stay stable until consumed.
REQ-021 On redirect, the output register and skid SHALL be invalidated on the next edge, instr_valid=0, and pc<=redirect_pc; the word consumed in the redirect cycle SHALL count as taken.
REQ-022 Redirect in REQ without imem_ack SHALL move to DROP.
REQ-023 Redirect in REQ with imem_ack SHALL discard the word and stay in REQ at redirect_pc.
REQ-024 Redirect in HOLD SHALL move to REQ at redirect_pc.
REQ-025 DROP SHALL hold the old imem_addr until imem_ack, discard the data, then enter REQ at the latest pending redirect target.
REQ-026 A redirect in DROP SHALL overwrite the pending target and stay in DROP.

Reset
REQ-027 While rst=1, the block SHALL hold state=REQ, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, and skid empty.
REQ-028 imem_req SHALL first assert the cycle after rst deasserts.
REQ-029 rst mid-operation SHALL abandon any in-flight request; the memory shares rst, so no stale imem_ack is honoured.

Configuration
REQ-030 The macro FETCH_MISALIGN_TRAP_EN, when defined, SHALL add output fetch_fault (1 bit, reset 0).
REQ-031 With FETCH_MISALIGN_TRAP_EN, a redirect with redirect_pc[1:0]!=0 SHALL set fetch_fault sticky, issue no request, and hold until the next aligned redirect or rst.
REQ-032 Without FETCH_MISALIGN_TRAP_EN, there SHALL be no fetch_fault port and redirect_pc[1:0] SHALL be forced to 2'b00.

Structure
REQ-033 Shared package cpu_pkg SHALL hold XLEN=32, INSTR_BYTES=4, and typedef fetch_state_t {REQ, HOLD, DROP}.
REQ-034 The block SHALL use one sub-module, fetch_skid_buf, a 2-entry valid/ready buffer carrying {pc, instr}.

Verification
REQ-035 Reset release, with imem_ack=1 every cycle and instr_ready=1 -> addresses 0,4,8,C and instr_valid continuous from cycle 2.
REQ-036 instr_ready=0 for 3 cycles while imem_ack=1 -> two words buffered, imem_req=0, no loss or duplication, order preserved on release.
REQ-037 redirect to 0x100 while waiting, with ack arriving 2 cycles later -> that data is dropped and the next imem_addr is 0x100.
REQ-038 redirect coincident with imem_ack -> word discarded, next instr_pc=redirect_pc.
REQ-039 pc=FFFF_FFFC fetched -> next imem_addr=0000_0000.
REQ-040 With FETCH_MISALIGN_TRAP_EN, redirect_pc=0x102 -> fetch_fault=1 and imem_req=0; a later redirect to 0x200 clears fetch_fault and fetches from 0x200.
